// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths/depths and the receive-entry layout.
// An entry is {frame_err, data}: error bit at position WIDTH, data in WIDTH-1:0.
package uart_pkg;

  localparam int UART_WIDTH    = 8;
  localparam int RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                  frame_err;
    logic [UART_WIDTH-1:0] data;
  } rx_entry_t;

  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array FIFO storage: registered write port, asynchronous read port.
// Contents are intentionally not reset; shared by the receive and transmit buffers.
module fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_fifo.sv
// UART receive buffer: first-word-fall-through FIFO capturing {frame_err, data}
// from the receiver ready pulse, with level/flag decode and a sticky overrun flag.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH       = UART_WIDTH,
  parameter int DEPTH       = RX_FIFO_DEPTH,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  input  logic                   wr_error,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_frame_err,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  input  logic                   flush,
  input  logic                   clr_overrun,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = entry_width(WIDTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;

  logic          w_wf;
  logic          w_rf;
  logic          w_ovr_set;
  logic [EW-1:0] w_wentry;
  logic [EW-1:0] w_rentry;

  // Flags come only from the registered level, never from rd_ready.
  assign full        = (r_level == LW'(DEPTH));
  assign empty       = (r_level == '0);
  assign almost_full = (r_level >= LW'(AFULL_LEVEL));
  assign rd_valid    = ~empty;
  assign level       = r_level;
  assign overrun     = r_overrun;

  assign w_rf      = rd_valid & rd_ready & ~flush;
  assign w_wf      = wr_valid & ~flush & (~full | w_rf);
  assign w_ovr_set = wr_valid & full & ~w_rf & ~flush;

  assign w_wentry     = {wr_error, wr_data};
  assign rd_data      = w_rentry[WIDTH-1:0];
  assign rd_frame_err = w_rentry[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wf) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rf) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wf && !w_rf) begin
        r_level <= r_level + 1'b1;
      end else if (w_rf && !w_wf) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wf),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wentry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rentry)
  );

endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive buffer between the UART receiver core and the register/bus interface. It captures each completed character, and the framing-error status that arrives with it, from the receiver's one-cycle ready pulse. Characters are stored in a first-word-fall-through FIFO and presented to the consumer through a valid/ready read port. It reports fill level, full/empty/almost-full, and a sticky overrun flag.

## Interface
- WIDTH, 8, character width; matches the receiver data width
- DEPTH, 16, number of entries; power of two, at least 2
- AFULL_LEVEL, 12, `almost_full` asserts when level is at least this value; range 1..DEPTH
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low; clock clk
- wr_data  input  WIDTH  received character, connected to receiver `rx_data_out`
- wr_valid  input  1  one-cycle write strobe, connected to receiver `rx_ready`
- wr_error  input  1  framing error for this character, connected to receiver `rx_error`; sampled only when `wr_valid`=1
- rd_data  output  WIDTH  head-entry character; valid while `rd_valid`=1
- rd_frame_err  output  1  head-entry framing-error bit
- rd_valid  output  1  FIFO not empty
- rd_ready  input  1  consumer accepts head entry when `rd_valid`=1
- flush  input  1  synchronous discard of all entries
- clr_overrun  input  1  clears `overrun`
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- almost_full  output  1  level >= AFULL_LEVEL
- overrun  output  1  sticky: a write was dropped

## Operation
- Each entry is {wr_error, wr_data}, WIDTH+1 bits wide.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `level` is a separate registered counter.
- Write fire (wf) = wr_valid & ~flush & (~full | rf). A write into a full FIFO is accepted when a read fires in the same cycle.
- Read fire (rf) = rd_valid & rd_ready & ~flush.
- Level update:
  - wf & ~rf: +1
  - rf & ~wf: −1
  - both or neither: unchanged
- Overrun: wr_valid & full & ~rf & ~flush sets `overrun`. The character is discarded, and pointers and level are unchanged.
- `clr_overrun` clears `overrun`. If a set and a clear occur in the same cycle, the set wins.
- `flush` takes priority over all other activity:
  - both pointers go to 0 and `level` goes to 0 on the next edge;
  - a write or read in the same cycle is ignored;
  - `overrun` is not affected by flush;
  - a wr_valid during flush does not set `overrun`.
- `rd_data`/`rd_frame_err` are combinational reads of mem[rd_ptr]. When `empty`=1 their value is don't-care.
- `full`, `empty` and `almost_full` are decoded from the registered `level`. They do not depend combinationally on `rd_ready`.
- `wr_error` is stored per entry and is not sticky. Error accounting belongs to the consumer.

## Timing
- Reset values:
  - pointers 0, `level` 0, `overrun` 0;
  - `empty`=1, `full`=0, `almost_full`=0, `rd_valid`=0;
  - memory contents are not reset.
- Write-to-read latency is 1 cycle. wr_valid at edge N makes `rd_valid`=1 and `rd_data` = that character after edge N.
- Read: when rf occurs at edge N, the next entry appears on `rd_data` after edge N. Back-to-back reads at one per cycle are supported.
- Full throughput is one write and one read per cycle, in any combination.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronously). Stored data is lost.
- The receiver produces at most one write per character time, so wr_valid is never assumed to be back-to-back. The FIFO still handles consecutive-cycle writes correctly.

## Structure
- A shared package `uart_pkg` holds:
  - the default data width constant `UART_WIDTH`=8;
  - the entry layout (error bit at position WIDTH, data at WIDTH-1:0);
  - the default `RX_FIFO_DEPTH`=16.
- Sub-module `fifo_mem`, parameterized by WIDTH+1 and DEPTH, is a register array with:
  - a one-cycle-registered write port;
  - an asynchronous read port.
  
  It is reusable by the future transmit buffer.
- `rx_fifo` contains the pointers, the level counter, the flag decode, the overrun logic and the fire qualification.

## Test plan
- Reset → `empty`=1, `level`=0, `rd_valid`=0, `overrun`=0. Write 0xA5 with `wr_error`=0 → the next cycle shows `rd_valid`=1, `rd_data`=0xA5, `rd_frame_err`=0, `level`=1.
- Write 16 characters 0x00..0x0F, then read with `rd_ready` held at 1 → characters come out in order at one per cycle. `full`=1 at level 16, `almost_full` asserts at level 12, and `empty`=1 afterwards. Pointers have wrapped.
- Fill to 16, then write 0x77 with `rd_ready`=0 → `overrun`=1, `level` stays 16, and the head is still 0x00. Then `clr_overrun` → `overrun`=0.
- Full FIFO, with wr_valid (0x55) and a read firing in the same cycle → no overrun and `level` stays 16. The last entry read out is 0x55.
- Write 0x3C with `wr_error`=1, followed by 0x3D with `wr_error`=0 → `rd_frame_err` reads 1 then 0, and the data matches.
- Level 5, assert `flush` together with wr_valid → next cycle `level`=0, `empty`=1, and `overrun` is unchanged. Assert rst_n low mid-burst → outputs return to reset values immediately.
